sample_window_writer: RTL and testbench

- Streaming producer for modiff_module. It accepts audio samples one per handshake and shifts them into a window of N = (1<<WINDOW_SIZE_BITS)+MAX_TAU samples.
- It presents the window on the same flat bus layout that modiff_module reads on its data port: sample i occupies bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH], and i=0 is the oldest sample.
- It freezes the window while modiff_module computes. After modiff_module signals completion, it refills only HOP new samples, giving overlapping analysis frames.

---
 rtl/modiff_pkg.sv | 19 +
 rtl/window_shift_reg.sv | 27 ++
 rtl/sample_window_writer.sv | 91 +++++++++
 tb/tb_sample_window_writer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modiff_pkg.sv
// rtl/modiff_pkg.sv - shared window geometry, flat-bus slot helper and writer states
package modiff_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } writer_state_t;

   // Window length N: analysis window plus the extra lag samples.
   function automatic int win_samples(input int window_size_bits, input int max_tau);
      return (1 << window_size_bits) + max_tau;
   endfunction

   // LSB position of sample slot i on the flat bus; slot 0 is the oldest sample.
   function automatic int slot_lsb(input int i, input int data_width);
      return i * data_width;
   endfunction

endpackage

// File: rtl/window_shift_reg.sv
// rtl/window_shift_reg.sv - N-slot sample shift register with enable, synchronous clear and flat output
module window_shift_reg
   import modiff_pkg::*;
#(
   parameter int N          = 296,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    clear,
   input  logic                    shift,
   input  logic [DATA_WIDTH-1:0]   sample,
   output logic [N*DATA_WIDTH-1:0] data
);

   // Each shift moves every slot one step toward slot 0; the new sample lands in slot N-1.
   always_ff @(posedge clk) begin
      if (clear) begin
         data <= '0;
      end else if (shift) begin
         for (int i = 0; i < N - 1; i++) begin
            data[slot_lsb(i, DATA_WIDTH) +: DATA_WIDTH] <= data[slot_lsb(i + 1, DATA_WIDTH) +: DATA_WIDTH];
         end
         data[slot_lsb(N - 1, DATA_WIDTH) +: DATA_WIDTH] <= sample;
      end
   end

endmodule

// File: rtl/sample_window_writer.sv
// rtl/sample_window_writer.sv - fills and freezes overlapping sample windows for modiff_module
module sample_window_writer
   import modiff_pkg::*;
#(
   parameter int DATA_WIDTH       = 8,
   parameter int WINDOW_SIZE_BITS = 8,
   parameter int MAX_TAU          = 40,
   parameter int HOP              = 128,
   parameter int FRAME_CNT_BITS   = 16
) (
   input  logic                                                         clk,
   input  logic                                                         reset,
   input  logic [DATA_WIDTH-1:0]                                        in_sample,
   input  logic                                                         in_valid,
   output logic                                                         in_ready,
   output logic [win_samples(WINDOW_SIZE_BITS, MAX_TAU)*DATA_WIDTH-1:0] data,
   output logic                                                         frame_valid,
   input  logic                                                         consumer_done,
   output logic [FRAME_CNT_BITS-1:0]                                    frame_count
);

   localparam int N     = win_samples(WINDOW_SIZE_BITS, MAX_TAU);
   localparam int CNT_W = $clog2(N + 1);

   generate
      if (HOP < 1 || HOP > N) begin : g_bad_hop
         $error("sample_window_writer: HOP must be within 1..N");
      end
   endgenerate

   writer_state_t    state;
   logic [CNT_W-1:0] fill_cnt;
   logic [CNT_W-1:0] fill_cnt_next;
   logic [CNT_W-1:0] target;
   logic             first_fill;
   logic             accept;

   assign in_ready      = (state == FILL) && !reset;
   assign accept        = in_valid && in_ready;
   assign fill_cnt_next = fill_cnt + CNT_W'(1);
   // The first frame after reset needs a whole window; later frames only refill HOP samples.
   assign target        = first_fill ? CNT_W'(N) : CNT_W'(HOP);

   window_shift_reg #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_window (
      .clk    (clk),
      .clear  (reset),
      .shift  (accept),
      .sample (in_sample),
      .data   (data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FILL;
         fill_cnt    <= '0;
         first_fill  <= 1'b1;
         frame_valid <= 1'b0;
         frame_count <= '0;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  if (fill_cnt_next == target) begin
                     state       <= HOLD;
                     fill_cnt    <= '0;
                     first_fill  <= 1'b0;
                     frame_valid <= 1'b1;
                     frame_count <= frame_count + FRAME_CNT_BITS'(1);
                  end else begin
                     fill_cnt <= fill_cnt_next;
                  end
               end
            end
            HOLD: begin
               if (consumer_done) begin
                  state       <= FILL;
                  frame_valid <= 1'b0;
               end
            end
            default: begin
               state       <= FILL;
               frame_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sample_window_writer.sv
// tb/tb_sample_window_writer.sv - randomized self-checking bench for sample_window_writer
module tb_sample_window_writer;
   import modiff_pkg::*;

   localparam int DW  = 8;
   localparam int WSB = 8;
   localparam int MT  = 40;
   localparam int HOP = 128;
   localparam int FCB = 16;
   localparam int N   = win_samples(WSB, MT);

   logic            clk = 1'b0;
   logic            reset;
   logic [DW-1:0]   in_sample;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] data;
   logic            frame_valid;
   logic            consumer_done;
   logic [FCB-1:0]  frame_count;

   always #5 clk = ~clk;

   sample_window_writer #(
      .DATA_WIDTH       (DW),
      .WINDOW_SIZE_BITS (WSB),
      .MAX_TAU          (MT),
      .HOP              (HOP),
      .FRAME_CNT_BITS   (FCB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_sample     (in_sample),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .data          (data),
      .frame_valid   (frame_valid),
      .consumer_done (consumer_done),
      .frame_count   (frame_count)
   );

   int checks   = 0;
   int failures = 0;
   int ramp     = 0;

   // Reference: the window is simply the last N accepted samples (zeros before that);
   // a frame completes when the accepted total reaches N, N+HOP, N+2*HOP, ...
   logic [DW-1:0] hist[$];
   bit            m_hold;
   int            m_acc;
   int            m_next;
   int            m_frames;

   task automatic model_reset();
      hist.delete();
      m_hold   = 1'b0;
      m_acc    = 0;
      m_next   = N;
      m_frames = 0;
   endtask

   function automatic logic [DW-1:0] exp_slot(input int i);
      int pad;
      pad = N - hist.size();
      if (i < pad) return '0;
      return hist[i - pad];
   endfunction

   function automatic logic [DW-1:0] dut_slot(input int i);
      return data[slot_lsb(i, DW) +: DW];
   endfunction

   task automatic tick(input bit v, input logic [DW-1:0] s, input bit d);
      in_valid      = v;
      in_sample     = s;
      consumer_done = d;
      if (reset) begin
         model_reset();
      end else if (!m_hold) begin
         if (v) begin
            hist.push_back(s);
            if (hist.size() > N) void'(hist.pop_front());
            m_acc++;
            if (m_acc == m_next) begin
               m_hold = 1'b1;
               m_frames++;
               m_next += HOP;
            end
         end
      end else if (d) begin
         m_hold = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(1'b0, '0, 1'b0);
      tick(1'b1, 8'hA5, 1'b1);
      checks++;
      if (data !== '0) begin failures++; $display("FAIL reset_data: got nonzero window, want 0"); end
      checks++;
      if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
      checks++;
      if (frame_count !== '0) begin failures++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_first_fill();
      int rdy_cnt = 0;
      int bad     = 0;
      for (int i = 0; i < N; i++) begin
         if (in_ready === 1'b1) rdy_cnt++;
         if (i == N - 1) begin
            checks++;
            if (frame_valid !== 1'b0) begin failures++; $display("FAIL fill_early_frame: got %b want 0", frame_valid); end
         end
         tick(1'b1, DW'(ramp), 1'b0);
         ramp++;
      end
      checks++;
      if (rdy_cnt != N) begin failures++; $display("FAIL fill_ready_count: got %0d want %0d", rdy_cnt, N); end
      checks++;
      if (frame_valid !== 1'b1) begin failures++; $display("FAIL fill_frame_valid: got %b want 1", frame_valid); end
      checks++;
      if (frame_count !== FCB'(1)) begin failures++; $display("FAIL fill_frame_count: got %0d want 1", frame_count); end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
      for (int i = 0; i < N; i++) if (dut_slot(i) !== DW'(i % 256)) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL fill_ramp_slots: %0d slots differ, want slot i == i mod 256", bad); end
   endtask

   task automatic test_hold_freeze();
      logic [N*DW-1:0] saved;
      int bad = 0;
      saved = data;
      for (int k = 0; k < 50; k++) begin
         tick(1'b1, DW'($urandom), 1'b0);
         if (data !== saved || frame_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL hold_freeze: %0d cycles changed, want 0", bad); end
   endtask

   task automatic test_hop_refill();
      int bad = 0;
      tick(1'b0, '0, 1'b1);
      checks++;
      if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL hop_done_edge: frame_valid=%b in_ready=%b want 0/1", frame_valid, in_ready);
      end
      for (int k = 0; k < HOP; k++) begin
         if (k == HOP - 1) begin
            checks++;
            if (frame_valid !== 1'b0) begin failures++; $display("FAIL hop_early_frame: got %b want 0", frame_valid); end
         end
         tick(1'b1, DW'(ramp), 1'b0);
         ramp++;
      end
      checks++;
      if (frame_valid !== 1'b1) begin failures++; $display("FAIL hop_frame_valid: got %b want 1", frame_valid); end
      checks++;
      if (frame_count !== FCB'(2)) begin failures++; $display("FAIL hop_frame_count: got %0d want 2", frame_count); end
      for (int i = 0; i < N; i++) if (dut_slot(i) !== DW'((i + 128) % 256)) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL hop_slots: %0d slots differ, want (i+128) mod 256", bad); end
   endtask

   task automatic test_done_in_fill();
      int bad = 0;
      tick(1'b0, '0, 1'b1);
      for (int k = 0; k < HOP; k++) begin
         if (k == HOP - 1) begin
            checks++;
            if (frame_valid !== 1'b0) begin failures++; $display("FAIL dfill_early_frame: got %b want 0", frame_valid); end
         end
         tick(1'b1, DW'(ramp), 1'b1);
         ramp++;
      end
      checks++;
      if (frame_valid !== 1'b1) begin failures++; $display("FAIL dfill_frame_valid: got %b want 1", frame_valid); end
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, '0, 1'b0);
         if (frame_valid !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL dfill_not_remembered: left HOLD %0d times, want 0", bad); end
      checks++;
      if (frame_count !== FCB'(3)) begin failures++; $display("FAIL dfill_frame_count: got %0d want 3", frame_count); end
      for (int i = 0; i < N; i++) if (dut_slot(i) !== exp_slot(i)) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL dfill_slots: %0d slots differ from model", bad); end
      tick(1'b0, '0, 1'b1);
      checks++;
      if (frame_valid !== 1'b0) begin failures++; $display("FAIL dfill_exit_hold: got %b want 0", frame_valid); end
   endtask

   task automatic test_reset_mid_fill();
      int bad = 0;
      for (int k = 0; k < 200; k++) begin
         tick(1'b1, DW'(ramp), 1'b0);
         ramp++;
      end
      reset = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); end
      tick(1'b1, 8'h3C, 1'b0);
      checks++;
      if (data !== '0 || frame_count !== '0 || frame_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_clear: data_zero=%b frame_count=%0d frame_valid=%b want 1/0/0",
                  (data == '0), frame_count, frame_valid);
      end
      reset = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (k == N - 1) begin
            checks++;
            if (frame_valid !== 1'b0) begin failures++; $display("FAIL rst_refill_early: got %b want 0", frame_valid); end
         end
         tick(1'b1, DW'(ramp), 1'b0);
         ramp++;
      end
      checks++;
      if (frame_valid !== 1'b1 || frame_count !== FCB'(1)) begin
         failures++;
         $display("FAIL rst_refill_frame: frame_valid=%b frame_count=%0d want 1/1", frame_valid, frame_count);
      end
      for (int i = 0; i < N; i++) if (dut_slot(i) !== exp_slot(i)) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL rst_refill_slots: %0d slots differ from model", bad); end
   endtask

   task automatic test_random_gaps();
      int  start_frames;
      int  hold_cnt = 0;
      int  cycles   = 0;
      int  printed  = 0;
      bit  was_hold;
      bit  v;
      bit  d;
      start_frames = m_frames;
      while (m_frames < start_frames + 5 && cycles < 20000) begin
         v = ($urandom_range(0, 1) == 1);
         d = (hold_cnt >= 10);
         was_hold = m_hold;
         tick(v, DW'(ramp), d);
         if (v && !was_hold) ramp++;
         cycles++;
         checks++;
         if (frame_valid !== m_hold || in_ready !== !m_hold) begin
            failures++;
            if (printed < 10) begin
               printed++;
               $display("FAIL gaps_handshake: cycle %0d frame_valid=%b in_ready=%b want %b/%b",
                        cycles, frame_valid, in_ready, m_hold, !m_hold);
            end
         end
         if (m_hold && !was_hold) begin
            int bad = 0;
            for (int i = 0; i < N; i++) if (dut_slot(i) !== exp_slot(i)) bad++;
            checks++;
            if (bad != 0) begin failures++; $display("FAIL gaps_window: frame %0d has %0d slots off model", m_frames, bad); end
            checks++;
            if (frame_count !== FCB'(m_frames)) begin
               failures++;
               $display("FAIL gaps_frame_count: got %0d want %0d", frame_count, FCB'(m_frames));
            end
         end
         if (m_hold) hold_cnt++;
         else hold_cnt = 0;
      end
      checks++;
      if (m_frames < start_frames + 5) begin
         failures++;
         $display("FAIL gaps_timeout: got %0d frames want %0d", m_frames - start_frames, 5);
      end
   endtask

   initial begin
      model_reset();
      reset         = 1'b1;
      in_valid      = 1'b0;
      in_sample     = '0;
      consumer_done = 1'b0;
      test_reset();
      test_first_fill();
      test_hold_freeze();
      test_hop_refill();
      test_done_in_fill();
      test_reset_mid_fill();
      test_random_gaps();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
